piso_tx: RTL and testbench

Parallel-in serial-out transmitter for the shift-register family. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a single serial line. A framing strobe marks the first bit of each word. It is the transmit end of the serial link whose receive end deserializes back into a parallel register.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_tx.sv | 140 ++++++++++++++
 tb/tb_piso_tx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso serial link (transmitter and matching receiver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piso_pkg;

    // Word width used by both ends of the link unless overridden per instance.
    localparam int WIDTH_DEFAULT = 4;

    // Transmitter frame state. PARITY is only reachable when PISO_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word in, one bit per clock out, frame_start on bit 0.
// Latency: first bit on sout the cycle after the transfer edge; outputs are registered.
// Backpressure: in_ready only in IDLE and in the frame's final cycle (optional PISO_PARITY_EN adds a parity bit).
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             rdy;
    logic             load;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Bit that leaves the word first for the configured bit order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit into the head position, zero-filling the vacated end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Next-state, handshake and next-output logic for the frame FSM.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        sout_d        = 1'b0;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        rdy           = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d      = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                rdy = 1'b1;
            end
            SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    // The register already excludes the bit on sout, so its head is the next bit.
                    sout_d       = head_bit(shreg_q);
                    sout_valid_d = 1'b1;
                    shreg_d      = advance(shreg_q);
                    cnt_d        = cnt_q + CW'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    state_d      = PARITY;
                    sout_d       = parity_q;
                    sout_valid_d = 1'b1;
`else
                    // Last data bit is on the line: a new word may follow with no gap.
                    rdy          = 1'b1;
                    state_d      = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                rdy     = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready = rdy && !rst;
        load     = in_valid && in_ready;

        // A transfer overrides the end-of-frame decision, giving back-to-back frames.
        if (load) begin
            state_d       = SHIFT;
            shreg_d       = advance(in);
            cnt_d         = '0;
            sout_d        = head_bit(in);
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d      = ^in;
`endif
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
`ifdef PISO_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share one stimulus stream.
// A queue model predicts each cycle's outputs; scenario tasks also check fixed bit patterns.
module tb_piso_tx;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_w;

    logic m_rdy, m_sout, m_sv, m_fs, m_busy;
    logic l_rdy, l_sout, l_sv, l_fs, l_busy;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in(in_w), .in_valid(in_valid), .in_ready(m_rdy),
        .sout(m_sout), .sout_valid(m_sv), .frame_start(m_fs), .busy(m_busy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in(in_w), .in_valid(in_valid), .in_ready(l_rdy),
        .sout(l_sout), .sout_valid(l_sv), .frame_start(l_fs), .busy(l_busy)
    );

    // Observed outputs of both instances: {sout, sout_valid, frame_start, busy, in_ready} x2.
    logic [9:0] obs;
    assign obs = {m_sout, m_sv, m_fs, m_busy, m_rdy, l_sout, l_sv, l_fs, l_busy, l_rdy};

    int checks = 0;
    int passes = 0;

    // Model: queue of bits still to be sent per bit order, items are {first, bit}.
    bit [1:0] qm[$];
    bit [1:0] ql[$];
    bit [1:0] cm, cl;
    bit       cm_v, cl_v;
    bit       acc;

    logic [9:0]  expv;
    logic [15:0] got;
    logic [15:0] fsg;
    int          n;

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back({(i == 0), w[W-1-i]});
            ql.push_back({(i == 0), w[i]});
        end
`ifdef PISO_PARITY_EN
        qm.push_back({1'b0, ^w});
        ql.push_back({1'b0, ^w});
`endif
    endtask

    // One clock edge: advance the model with the inputs presented at that edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
            cm_v = 1'b0;
            cl_v = 1'b0;
            acc  = 1'b0;
        end else begin
            acc = in_valid && (qm.size() == 0);
            if (acc) push_frame(in_w);
            if (qm.size() > 0) begin cm = qm.pop_front(); cm_v = 1'b1; end else cm_v = 1'b0;
            if (ql.size() > 0) begin cl = ql.pop_front(); cl_v = 1'b1; end else cl_v = 1'b0;
        end
        #1;
    endtask

    function automatic logic [9:0] exp_vec();
        return {cm_v & cm[0], cm_v, cm_v & cm[1], cm_v, !rst && (qm.size() == 0),
                cl_v & cl[0], cl_v, cl_v & cl[1], cl_v, !rst && (ql.size() == 0)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_w = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (obs !== 10'b0) $display("FAIL reset_values cyc %0d: got %b want %b", c, obs, 10'b0);
            else passes++;
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] want;
`ifdef PISO_PARITY_EN
        want = 16'b10111;
`else
        want = 16'b1011;
`endif
        in_w = 4'b1011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got = '0; n = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            expv = exp_vec();
            checks++;
            if (obs !== expv) $display("FAIL single cyc %0d: got %b want %b", c, obs, expv);
            else passes++;
            if (m_sv) begin got = {got[14:0], m_sout}; n++; end
            step();
        end
        checks++;
        if (got !== want || n != FB) $display("FAIL single_msb_stream: got %b (%0d bits) want %b", got, n, want);
        else passes++;
    endtask

    task automatic test_lsb_first();
        logic [15:0] want;
`ifdef PISO_PARITY_EN
        want = 16'b00110;
`else
        want = 16'b0011;
`endif
        in_w = 4'b1100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got = '0; n = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            expv = exp_vec();
            checks++;
            if (obs !== expv) $display("FAIL lsb_first cyc %0d: got %b want %b", c, obs, expv);
            else passes++;
            if (l_sv) begin got = {got[14:0], l_sout}; n++; end
            step();
        end
        checks++;
        if (got !== want || n != FB) $display("FAIL lsb_first_stream: got %b (%0d bits) want %b", got, n, want);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] want, want_fs;
        int idx, rdy_busy;
`ifdef PISO_PARITY_EN
        want    = 16'b1010001100;
        want_fs = 16'b1000010000;
`else
        want    = 16'b10100110;
        want_fs = 16'b10001000;
`endif
        idx = 0; rdy_busy = 0;
        in_w = 4'b1010; in_valid = 1'b1;
        got = '0; fsg = '0; n = 0;
        for (int c = 0; c < 2 * W + 5; c++) begin
            step();
            if (acc) begin
                idx++;
                if (idx == 1) in_w = 4'b0110;
                else in_valid = 1'b0;
            end
            @(negedge clk);
            expv = exp_vec();
            checks++;
            if (obs !== expv) $display("FAIL back_to_back cyc %0d: got %b want %b", c, obs, expv);
            else passes++;
            if (m_sv) begin got = {got[14:0], m_sout}; fsg = {fsg[14:0], m_fs}; n++; end
            if (m_rdy && m_busy) rdy_busy++;
        end
        checks++;
        if (got !== want || fsg !== want_fs || n != 2 * FB)
            $display("FAIL back_to_back_stream: got %b fs %b (%0d bits) want %b fs %b", got, fsg, n, want, want_fs);
        else passes++;
        checks++;
        if (rdy_busy != 2) $display("FAIL back_to_back_ready: got %0d ready cycles want 2", rdy_busy);
        else passes++;
    endtask

    task automatic test_busy_ignore();
        logic [15:0] want;
        int idx;
`ifdef PISO_PARITY_EN
        want = 16'b1001011110;
`else
        want = 16'b10011111;
`endif
        idx = 0;
        in_w = 4'b1001; in_valid = 1'b1;
        got = '0; n = 0;
        for (int c = 0; c < 2 * W + 5; c++) begin
            step();
            if (acc) idx++;
            if (idx == 1 && c == 0) in_valid = 1'b0;
            if (idx == 1 && c == 1) begin in_w = 4'b1111; in_valid = 1'b1; end
            if (idx == 2) in_valid = 1'b0;
            @(negedge clk);
            expv = exp_vec();
            checks++;
            if (obs !== expv) $display("FAIL busy_ignore cyc %0d: got %b want %b", c, obs, expv);
            else passes++;
            if (m_sv) begin got = {got[14:0], m_sout}; n++; end
        end
        checks++;
        if (got !== want || n != 2 * FB) $display("FAIL busy_ignore_stream: got %b (%0d bits) want %b", got, n, want);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] want;
`ifdef PISO_PARITY_EN
        want = 16'b00110;
`else
        want = 16'b0011;
`endif
        in_w = 4'b1101; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        expv = exp_vec();
        checks++;
        if (obs !== expv) $display("FAIL reset_mid_assert: got %b want %b", obs, expv);
        else passes++;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 10'b00001_00001) $display("FAIL reset_mid_after: got %b want %b", obs, 10'b00001_00001);
        else passes++;
        in_w = 4'b0011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got = '0; n = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            expv = exp_vec();
            checks++;
            if (obs !== expv) $display("FAIL reset_mid_resend cyc %0d: got %b want %b", c, obs, expv);
            else passes++;
            if (m_sv) begin got = {got[14:0], m_sout}; n++; end
            step();
        end
        checks++;
        if (got !== want || n != FB) $display("FAIL reset_mid_stream: got %b (%0d bits) want %b", got, n, want);
        else passes++;
    endtask

    task automatic test_random();
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && ($urandom_range(0, 1) == 1)) begin
                in_w = W'($urandom);
                in_valid = 1'b1;
            end
            rst = ($urandom_range(0, 59) == 0);
            step();
            if (acc) in_valid = 1'b0;
            @(negedge clk);
            expv = exp_vec();
            checks++;
            if (obs !== expv) $display("FAIL random cyc %0d: got %b want %b", c, obs, expv);
            else passes++;
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        cm = '0; cl = '0; cm_v = 1'b0; cl_v = 1'b0; acc = 1'b0;
        test_reset();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
